// File: rtl/mesh_rr_arbiter.sv
// Round-robin arbiter for one shared mesh output with multi-flit grant hold.
// Define ARB_HOLD_TIMEOUT_EN to bound a held grant to HOLD_MAX cycles.
module mesh_rr_arbiter #(
    parameter int N_PORTS  = 5,
    parameter int HOLD_MAX = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PORTS-1:0]         portRequest,
    input  logic [N_PORTS-1:0]         portHold,
    output logic [N_PORTS-1:0]         portGrant,
    output logic                       grantValid,
    output logic [$clog2(N_PORTS)-1:0] grantIndex,
    output logic                       holdTimeout
);

    localparam int IW = $clog2(N_PORTS);
    localparam logic [N_PORTS-1:0] ONE = N_PORTS'(1);

    // An out-of-range parameter fails elaboration on an unknown module.
    if (N_PORTS < 2 || N_PORTS > 16 || HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_bad_param
        mesh_rr_arbiter_illegal_parameter u_bad ();
    end

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t                 state;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          base;
    logic [IW-1:0]          next_ptr;
    logic [IW-1:0]          win_idx;
    logic                   found;
    logic                   owner_req;
    logic                   owner_hold;
    logic                   keep;
    logic                   timeout_hit;
    logic [2*N_PORTS-1:0]   req_dbl;
    logic [N_PORTS-1:0]     req_rot;
    logic [IW:0]            sum;

    always_comb begin
        owner_req  = portRequest[grantIndex];
        owner_hold = portHold[grantIndex];
        next_ptr   = (grantIndex == IW'(N_PORTS - 1)) ? '0 : grantIndex + 1'b1;
        keep       = (state == GRANTED) && owner_req && owner_hold && !timeout_hit;
        // A releasing owner scans from its successor, so it ranks last.
        base       = (state == GRANTED) ? next_ptr : ptr;
    end

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        sum     = '0;
        req_dbl = {portRequest, portRequest} >> base;
        req_rot = req_dbl[N_PORTS-1:0];
        for (int i = 0; i < N_PORTS; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, base} + (IW+1)'(i);
                if (sum >= (IW+1)'(N_PORTS)) begin
                    sum = sum - (IW+1)'(N_PORTS);
                end
                win_idx = sum[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            portGrant  <= '0;
            grantValid <= 1'b0;
            grantIndex <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state      <= GRANTED;
                        portGrant  <= ONE << win_idx;
                        grantValid <= 1'b1;
                        grantIndex <= win_idx;
                    end
                end
                GRANTED: begin
                    if (!keep) begin
                        ptr <= next_ptr;
                        if (found) begin
                            portGrant  <= ONE << win_idx;
                            grantIndex <= win_idx;
                        end else begin
                            state      <= IDLE;
                            portGrant  <= '0;
                            grantValid <= 1'b0;
                            grantIndex <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);

    logic [CW-1:0] hold_cnt;
    logic          timeout_q;

    // hold_cnt is the number of cycles the current grant has been visible.
    assign timeout_hit = (state == GRANTED) && owner_req && owner_hold &&
                         (hold_cnt == CW'(HOLD_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (keep) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else if (found) begin
                hold_cnt <= CW'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    assign holdTimeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign holdTimeout = 1'b0;
`endif

`ifndef SYNTHESIS
    a_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(portGrant));
    a_valid : assert property (@(posedge clk) disable iff (reset)
        grantValid == (|portGrant));
    a_index : assert property (@(posedge clk) disable iff (reset)
        grantValid ? portGrant[grantIndex] : (grantIndex == '0));
`endif

endmodule

// File: tb/tb_mesh_rr_arbiter.sv
// Table-driven scoreboard bench for mesh_rr_arbiter (N_PORTS=5, HOLD_MAX=4).
module tb_mesh_rr_arbiter;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] portRequest;
    logic [N-1:0] portHold;
    logic [N-1:0] portGrant;
    logic         grantValid;
    logic [2:0]   grantIndex;
    logic         holdTimeout;

    always #5 clk = ~clk;

    mesh_rr_arbiter #(
        .N_PORTS (N),
        .HOLD_MAX(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .portRequest(portRequest),
        .portHold   (portHold),
        .portGrant  (portGrant),
        .grantValid (grantValid),
        .grantIndex (grantIndex),
        .holdTimeout(holdTimeout)
    );

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] hold;
        logic [N-1:0] grant;
        logic         to;
    } vec_t;

    typedef struct {
        logic [N-1:0] grant;
        logic         to;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t tbl[25];
    int   checks = 0;
    int   errors = 0;
    bit   armed  = 1'b0;

    function automatic logic [2:0] idx_of(input logic [N-1:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic step(input string nm, input logic r, input logic [N-1:0] q,
                        input logic [N-1:0] h, input logic [N-1:0] g,
                        input logic t);
        @(negedge clk);
        reset       = r;
        portRequest = q;
        portHold    = h;
        sb.push_back('{g, t, nm});
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.name, " grant"}, 32'(portGrant), 32'(e.grant));
            check({e.name, " valid"}, 32'(grantValid), 32'(|e.grant));
            check({e.name, " index"}, 32'(grantIndex), 32'(idx_of(e.grant)));
            check({e.name, " timeout"}, 32'(holdTimeout), 32'(e.to));
            armed = 1'b1;
        end
        if (armed) begin
            check("onehot0", 32'($onehot0(portGrant)), 32'd1);
            check("valid_vs_grant", 32'(grantValid), 32'(|portGrant));
            check("index_vs_grant", 32'(grantIndex), 32'(idx_of(portGrant)));
        end
    end

    initial begin
        reset       = 1'b1;
        portRequest = '0;
        portHold    = '0;

        tbl = '{
            '{1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b0},
            '{1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b0},
            '{1'b0, 5'b11111, 5'b00000, 5'b00001, 1'b0},
            '{1'b0, 5'b00110, 5'b00000, 5'b00010, 1'b0},
            '{1'b0, 5'b00110, 5'b00000, 5'b00100, 1'b0},
            '{1'b0, 5'b00110, 5'b00000, 5'b00010, 1'b0},
            '{1'b0, 5'b00110, 5'b00000, 5'b00100, 1'b0},
            '{1'b0, 5'b00110, 5'b00010, 5'b00010, 1'b0},
            '{1'b0, 5'b00110, 5'b00010, 5'b00010, 1'b0},
            '{1'b0, 5'b00110, 5'b00010, 5'b00010, 1'b0},
            '{1'b0, 5'b00110, 5'b00000, 5'b00100, 1'b0},
            '{1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0},
            '{1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0},
            '{1'b0, 5'b00011, 5'b00000, 5'b00001, 1'b0},
            '{1'b0, 5'b00001, 5'b00000, 5'b00001, 1'b0},
            '{1'b0, 5'b10001, 5'b00000, 5'b10000, 1'b0},
            '{1'b0, 5'b10001, 5'b00000, 5'b00001, 1'b0},
            '{1'b0, 5'b01000, 5'b01000, 5'b01000, 1'b0},
            '{1'b0, 5'b01000, 5'b01000, 5'b01000, 1'b0},
            '{1'b1, 5'b01000, 5'b01000, 5'b00000, 1'b0},
            '{1'b0, 5'b01001, 5'b01001, 5'b00001, 1'b0},
            '{1'b0, 5'b01001, 5'b01001, 5'b00001, 1'b0},
            '{1'b0, 5'b01000, 5'b01001, 5'b01000, 1'b0},
            '{1'b0, 5'b01100, 5'b00100, 5'b00100, 1'b0},
            '{1'b0, 5'b00000, 5'b11111, 5'b00000, 1'b0}
        };

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].req,
                 tbl[i].hold, tbl[i].grant, tbl[i].to);
        end

        // From IDLE with pointer at 3: port 0 wins, then holds.
`ifdef ARB_HOLD_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            step($sformatf("to_hold%0d", k), 1'b0, 5'b00101, 5'b00001, 5'b00001, 1'b0);
        end
        step("to_fire", 1'b0, 5'b00101, 5'b00001, 5'b00100, 1'b1);
        step("to_after", 1'b0, 5'b00101, 5'b00001, 5'b00001, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("solo_hold%0d", k), 1'b0, 5'b00001, 5'b00001, 5'b00001, 1'b0);
        end
        step("solo_fire", 1'b0, 5'b00001, 5'b00001, 5'b00001, 1'b1);
        step("solo_after", 1'b0, 5'b00001, 5'b00001, 5'b00001, 1'b0);
`else
        for (int k = 0; k < 10; k++) begin
            step($sformatf("long_hold%0d", k), 1'b0, 5'b00101, 5'b00001, 5'b00001, 1'b0);
        end
        step("solo_hold", 1'b0, 5'b00001, 5'b00001, 5'b00001, 1'b0);
`endif
        step("final_idle", 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);

        for (int k = 0; k < 5; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        check("drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
